uart_cmd_ctrl: RTL and testbench

- Command sequencer behind the UART receiver. Consumes received bytes and their rx_done flag.
- Frames bytes into register-access commands: header, then little-endian payload.
- Drives one-cycle write/read/soft-reset strobes into the configuration register bank.
- Enforces an inter-byte timeout and counts framing errors.

---
 rtl/uart_cmd_ctrl_pkg.sv | 32 +++
 rtl/uart_byte_strobe.sv | 31 +++
 rtl/uart_cmd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants and header decode for the UART command sequencer.
package uart_cmd_ctrl_pkg;

  // Header opcodes
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RST   = 2'b11;

  // Header field positions
  localparam int unsigned OP_MSB   = 7;
  localparam int unsigned OP_LSB   = 6;
  localparam int unsigned ADDR_MSB = 5;
  localparam int unsigned ADDR_LSB = 0;

  // Sequencer states
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] addr;
  } hdr_t;

  function automatic hdr_t decode_hdr(input logic [7:0] b);
    hdr_t h;
    h.op   = b[OP_MSB:OP_LSB];
    h.addr = b[ADDR_MSB:ADDR_LSB];
    return h;
  endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's level done flag into a one-cycle byte strobe and
// captures the received byte.
module uart_byte_strobe (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       byte_stb,
  output logic [7:0] byte_data
);

  logic       rx_done_q;
  logic [7:0] data_q;

  // Rising edge of rx_done; the delayed copy resets high so a receiver that
  // comes out of reset with rx_done already high does not fire a strobe.
  assign byte_stb  = rx_done & ~rx_done_q;
  assign byte_data = byte_stb ? rx_data : data_q;

  // Edge-detect history and byte capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q <= 1'b1;
      data_q    <= '0;
    end else begin
      rx_done_q <= rx_done;
      if (byte_stb) data_q <= rx_data;
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Command sequencer: frames UART bytes into register write/read/reset
// commands with an inter-byte timeout and a saturating error counter.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned TIMEOUT    = 65535,
  parameter int unsigned TO_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_done,
  output logic [5:0]              cfg_addr,
  output logic [8*DATA_BYTES-1:0] cfg_data,
  output logic                    cfg_we,
  output logic                    rd_req,
  output logic                    soft_rst,
  output logic                    frame_err,
  output logic [7:0]              err_count,
  output logic                    busy
);

  localparam int unsigned DW   = 8 * DATA_BYTES;
  localparam int unsigned IdxW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [IdxW-1:0]     LastIdx = IdxW'(DATA_BYTES - 1);
  localparam logic [TO_WIDTH-1:0] ToMax   = TO_WIDTH'(TIMEOUT);

  logic            byte_stb;
  logic [7:0]      byte_data;
  hdr_t            hdr;

  logic [0:0]          state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [TO_WIDTH-1:0] to_cnt_q, to_cnt_d;
  logic [DW-1:0]       shadow_q, shadow_d;
  logic [5:0]          wr_addr_q, wr_addr_d;
  logic [5:0]          cfg_addr_q, cfg_addr_d;
  logic [DW-1:0]       cfg_data_q, cfg_data_d;
  logic                cfg_we_q, cfg_we_d;
  logic                rd_req_q, rd_req_d;
  logic                soft_rst_q, soft_rst_d;
  logic                frame_err_q, frame_err_d;
  logic [7:0]          err_count_q, err_count_d;

  uart_byte_strobe u_byte_strobe (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .byte_stb  (byte_stb),
    .byte_data (byte_data)
  );

  assign hdr = decode_hdr(byte_data);

  // Header decode, payload assembly and timeout; strobes default low so
  // each one lasts exactly one cycle and at most one fires per cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    to_cnt_d    = to_cnt_q;
    shadow_d    = shadow_q;
    wr_addr_d   = wr_addr_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    cfg_we_d    = 1'b0;
    rd_req_d    = 1'b0;
    soft_rst_d  = 1'b0;
    frame_err_d = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      ST_PAYLOAD: begin
        if (byte_stb) begin
          // A byte on the expiry cycle still counts: the strobe is checked first.
          shadow_d[8*idx_q +: 8] = byte_data;
          to_cnt_d = '0;
          if (idx_q == LastIdx) begin
            cfg_data_d = shadow_d;
            cfg_addr_d = wr_addr_q;
            cfg_we_d   = 1'b1;
            idx_d      = '0;
            state_d    = ST_IDLE;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else if (to_cnt_q == ToMax) begin
          frame_err_d = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          shadow_d = '0;
          idx_d    = '0;
          to_cnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_WIDTH'(1);
        end
      end
      default: begin
        to_cnt_d = '0;
        if (byte_stb) begin
          case (hdr.op)
            OP_WRITE: begin
              wr_addr_d = hdr.addr;
              shadow_d  = '0;
              idx_d     = '0;
              state_d   = ST_PAYLOAD;
            end
            OP_READ: begin
              cfg_addr_d = hdr.addr;
              rd_req_d   = 1'b1;
            end
            OP_RST:  soft_rst_d = 1'b1;
            default: ;
          endcase
        end
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      to_cnt_q    <= '0;
      shadow_q    <= '0;
      wr_addr_q   <= '0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      cfg_we_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      soft_rst_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      to_cnt_q    <= to_cnt_d;
      shadow_q    <= shadow_d;
      wr_addr_q   <= wr_addr_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      cfg_we_q    <= cfg_we_d;
      rd_req_q    <= rd_req_d;
      soft_rst_q  <= soft_rst_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_we    = cfg_we_q;
  assign rd_req    = rd_req_q;
  assign soft_rst  = soft_rst_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;
  assign busy      = (state_q == ST_PAYLOAD);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl (DATA_BYTES=4, TIMEOUT=100).
module tb_uart_cmd_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_we;
  logic        rd_req;
  logic        soft_rst;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_we     = 0;
  int n_rd     = 0;
  int n_srst   = 0;
  int n_ferr   = 0;
  int n_excl   = 0;

  uart_cmd_ctrl #(
    .DATA_BYTES (4),
    .TIMEOUT    (100),
    .TO_WIDTH   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_we    (cfg_we),
    .rd_req    (rd_req),
    .soft_rst  (soft_rst),
    .frame_err (frame_err),
    .err_count (err_count),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe tally and exclusivity watch, sampled mid-cycle
  always @(negedge clk) begin
    if (cfg_we)    n_we++;
    if (rd_req)    n_rd++;
    if (soft_rst)  n_srst++;
    if (frame_err) n_ferr++;
    if (int'(cfg_we) + int'(rd_req) + int'(soft_rst) + int'(frame_err) > 1) n_excl++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Byte strobe lands on the posedge after the first negedge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  int saved;
  int cyc;
  int missed;
  int ferr0;

  initial begin
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    #1;
    check_eq("rst_cfg_addr", 32'(cfg_addr), 32'h0);
    check_eq("rst_cfg_data", cfg_data, 32'h0);
    check_eq("rst_strobes", {28'h0, cfg_we, rd_req, soft_rst, frame_err}, 32'h0);
    check_eq("rst_err_count", 32'(err_count), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // WRITE frame
    send_byte(8'h45);
    check_eq("wr_busy_hdr", 32'(busy), 32'h1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check_eq("wr_busy_mid", 32'(busy), 32'h1);
    check_eq("wr_no_early_we", 32'(cfg_we), 32'h0);
    send_byte(8'h44);
    check_eq("wr_we", 32'(cfg_we), 32'h1);
    check_eq("wr_addr", 32'(cfg_addr), 32'h05);
    check_eq("wr_data", cfg_data, 32'h44332211);
    check_eq("wr_busy_done", 32'(busy), 32'h0);
    @(negedge clk);
    check_eq("wr_we_1cyc", 32'(cfg_we), 32'h0);

    // READ, RESET, NOP
    send_byte(8'h8A);
    check_eq("rd_req", 32'(rd_req), 32'h1);
    check_eq("rd_addr", 32'(cfg_addr), 32'h0A);
    check_eq("rd_data_hold", cfg_data, 32'h44332211);
    @(negedge clk);
    check_eq("rd_req_1cyc", 32'(rd_req), 32'h0);
    send_byte(8'hC0);
    check_eq("srst", 32'(soft_rst), 32'h1);
    check_eq("srst_addr_hold", 32'(cfg_addr), 32'h0A);
    @(negedge clk);
    check_eq("srst_1cyc", 32'(soft_rst), 32'h0);
    send_byte(8'h3F);
    check_eq("nop_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("cnt_we", 32'(n_we), 32'd1);
    check_eq("cnt_rd", 32'(n_rd), 32'd1);
    check_eq("cnt_srst", 32'(n_srst), 32'd1);

    // Timeout: expiry 101 cycles after the last strobe
    send_byte(8'h41);
    send_byte(8'hAA);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frame_err) begin
        cyc = i;
        break;
      end
    end
    check_eq("to_latency", 32'(cyc), 32'd101);
    check_eq("to_err_count", 32'(err_count), 32'd1);
    check_eq("to_busy", 32'(busy), 32'h0);
    check_eq("to_data_hold", cfg_data, 32'h44332211);
    @(negedge clk);
    check_eq("to_ferr_1cyc", 32'(frame_err), 32'h0);
    send_byte(8'h8A);
    check_eq("to_rd_req", 32'(rd_req), 32'h1);
    check_eq("to_rd_addr", 32'(cfg_addr), 32'h0A);
    #1;
    check_eq("to_no_we", 32'(n_we), 32'd1);

    // Tie: third byte strobes on the cycle the counter equals TIMEOUT
    send_byte(8'h42);
    send_byte(8'hBB);
    repeat (99) @(negedge clk);
    send_byte(8'hCC);
    check_eq("tie_busy", 32'(busy), 32'h1);
    send_byte(8'hDD);
    send_byte(8'hEE);
    check_eq("tie_we", 32'(cfg_we), 32'h1);
    check_eq("tie_addr", 32'(cfg_addr), 32'h02);
    check_eq("tie_data", cfg_data, 32'hEEDDCCBB);
    #1;
    check_eq("tie_no_ferr", 32'(n_ferr), 32'd1);

    // Reset mid-frame, with rx_done held high across the release
    send_byte(8'h45);
    send_byte(8'h11);
    send_byte(8'h22);
    check_eq("mid_busy", 32'(busy), 32'h1);
    #2;
    rst     = 1'b1;
    rx_done = 1'b1;
    rx_data = 8'h8A;
    #1;
    check_eq("mid_busy_rst", 32'(busy), 32'h0);
    check_eq("mid_addr_rst", 32'(cfg_addr), 32'h0);
    check_eq("mid_data_rst", cfg_data, 32'h0);
    check_eq("mid_err_rst", 32'(err_count), 32'h0);
    saved = n_rd + n_we + n_srst;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("mid_no_spurious", 32'(n_rd + n_we + n_srst), 32'(saved));
    check_eq("mid_busy_after", 32'(busy), 32'h0);
    send_byte(8'h45);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    check_eq("fresh_we", 32'(cfg_we), 32'h1);
    check_eq("fresh_addr", 32'(cfg_addr), 32'h05);
    check_eq("fresh_data", cfg_data, 32'h04030201);

    // Saturation over 300 timed-out frames
    #1;
    ferr0  = n_ferr;
    missed = 0;
    for (int f = 0; f < 300; f++) begin
      send_byte(8'h40);
      cyc = 0;
      for (int i = 1; i <= 150; i++) begin
        @(negedge clk);
        if (frame_err) begin
          cyc = i;
          break;
        end
      end
      if (cyc == 0) missed++;
      if (f == 9) check_eq("sat_err_10", 32'(err_count), 32'd10);
    end
    check_eq("sat_missed", 32'(missed), 32'd0);
    check_eq("sat_err_count", 32'(err_count), 32'd255);
    @(negedge clk);
    #1;
    check_eq("sat_ferr_pulses", 32'(n_ferr - ferr0), 32'd300);
    check_eq("exclusive", 32'(n_excl), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
